// File: rtl/accel_pkg.sv
// Shared opcodes and FSM state type for the accelerator stream driver.
package accel_pkg;

  localparam logic [1:0] OP_NOP         = 2'b00;
  localparam logic [1:0] OP_LOAD_KERNEL = 2'b01;
  localparam logic [1:0] OP_LOAD_NEURON = 2'b10;
  localparam logic [1:0] OP_READ_OUT    = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_READ,
    ST_DRAIN,
    ST_GAP
  } state_e;

endpackage

// File: rtl/accel_sync_fifo.sv
// Synchronous FIFO with occupancy count; no fall-through, push while full allowed when popping.
module accel_sync_fifo #(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             data_i,
  output logic [W-1:0]             data_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wptr_q, wptr_d;
  logic [AW:0]  rptr_q, rptr_d;
  logic         full, empty, do_push, do_pop;

  assign count_o = wptr_q - rptr_q;
  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty;
  assign do_push = push_i && (!full || do_pop);
  assign data_o  = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/accel_stream_driver.sv
// Host-side driver for the accelerator word-serial port: streams commands/data, collects read results.
// Optional ACCEL_DRV_STATS_EN adds sent_count/recv_count beat counters.
module accel_stream_driver
  import accel_pkg::*;
#(
  parameter int unsigned W          = 16,
  parameter int unsigned ABuffer    = 11,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned READ_LAT   = 2
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [ABuffer-1:0] cmd_len,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [W-1:0]       wr_data,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [W-1:0]       rd_data,
  output logic               busy,
  output logic [1:0]         instruction,
  output logic [W-1:0]       dataIn,
  input  logic [W-1:0]       dataOut
`ifdef ACCEL_DRV_STATS_EN
  ,
  output logic [31:0]        sent_count,
  output logic [31:0]        recv_count
`endif
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  state_e             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [ABuffer-1:0] len_q, len_d;
  logic [1:0]         instr_q, instr_d;
  logic [W-1:0]       din_q, din_d;
  logic [READ_LAT-1:0] vsr_q, vsr_d;

  logic [CW-1:0]      wr_cnt, rs_cnt;
  logic [W-1:0]       wr_head;
  logic               wr_pop, rs_push, rs_pop;
  int unsigned        inflight, free_slots;

  accel_sync_fifo #(.W(W), .DEPTH(FIFO_DEPTH)) u_wr_fifo (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .push_i  (wr_valid && wr_ready),
    .pop_i   (wr_pop),
    .data_i  (wr_data),
    .data_o  (wr_head),
    .count_o (wr_cnt)
  );

  accel_sync_fifo #(.W(W), .DEPTH(FIFO_DEPTH)) u_rs_fifo (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .push_i  (rs_push),
    .pop_i   (rs_pop),
    .data_i  (dataOut),
    .data_o  (rd_data),
    .count_o (rs_cnt)
  );

  assign wr_ready    = (32'(wr_cnt) != FIFO_DEPTH);
  assign rd_valid    = (rs_cnt != '0);
  assign rs_pop      = rd_valid && rd_ready;
  assign rs_push     = vsr_q[READ_LAT-1];
  assign cmd_ready   = (state_q == ST_IDLE) && RST_N;
  assign busy        = (state_q != ST_IDLE);
  assign instruction = instr_q;
  assign dataIn      = din_q;
  assign free_slots  = FIFO_DEPTH - 32'(rs_cnt);

  // The valid pipe starts from the registered READ beat so its tail lines up with dataOut.
  assign vsr_d = READ_LAT'({vsr_q, instr_q == OP_READ_OUT});

  always_comb begin
    inflight = (instr_q == OP_READ_OUT) ? 1 : 0;
    for (int unsigned i = 0; i < READ_LAT; i++) inflight += 32'(vsr_q[i]);
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    len_d   = len_q;
    instr_d = OP_NOP;
    din_d   = '0;
    wr_pop  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready && (cmd_len != '0)) begin
          op_d  = cmd_op;
          len_d = cmd_len;
          if (cmd_op == OP_NOP)           state_d = ST_GAP;
          else if (cmd_op == OP_READ_OUT) state_d = ST_READ;
          else                            state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (wr_cnt != '0) begin
          instr_d = op_q;
          din_d   = wr_head;
          wr_pop  = 1'b1;
          len_d   = len_q - ABuffer'(1);
          if (len_q == ABuffer'(1)) state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        // Credit rule: every issued read already owns a result slot.
        if (free_slots > inflight) begin
          instr_d = OP_READ_OUT;
          len_d   = len_q - ABuffer'(1);
          if (len_q == ABuffer'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (inflight == 0) state_d = ST_IDLE;
      end
      ST_GAP: begin
        len_d = len_q - ABuffer'(1);
        if (len_q == ABuffer'(1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NOP;
      len_q   <= '0;
      instr_q <= OP_NOP;
      din_q   <= '0;
      vsr_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      len_q   <= len_d;
      instr_q <= instr_d;
      din_q   <= din_d;
      vsr_q   <= vsr_d;
    end
  end

`ifdef ACCEL_DRV_STATS_EN
  logic [31:0] sent_q, recv_q;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sent_q <= '0;
      recv_q <= '0;
    end else begin
      if (instr_d != OP_NOP) sent_q <= sent_q + 32'd1;
      if (rs_push)           recv_q <= recv_q + 32'd1;
    end
  end

  assign sent_count = sent_q;
  assign recv_count = recv_q;
`endif

endmodule
